// File: rtl/state_update_ctrl_if.sv
// Stream-side handshake bundle of the state-update sequencer: bdi input words in, pdo words out.
interface state_update_ctrl_if;
    logic       bdi_valid;
    logic       bdi_ready;
    logic       bdi_last;
    logic [3:0] bdi_bval;
    logic       bdo_valid;
    logic       bdo_ready;
    logic       bdo_tag;

    // Stream side: supplies bdi words and consumes pdo words.
    modport master (
        output bdi_valid,
        output bdi_last,
        output bdi_bval,
        output bdo_ready,
        input  bdi_ready,
        input  bdo_valid,
        input  bdo_tag
    );

    // Controller side.
    modport slave (
        input  bdi_valid,
        input  bdi_last,
        input  bdi_bval,
        input  bdo_ready,
        output bdi_ready,
        output bdo_valid,
        output bdo_tag
    );
endinterface

// File: rtl/state_update_ctrl.sv
// Sequencer for the 32-bit state-update datapath and the round-based SKINNY core.
// Per 128-bit block: shift 4 words through the state (pdo handshaked out alongside),
// run ROUNDS cipher cycles, and after the final block shift the tag out with pdi zeroed.
module state_update_ctrl #(
    parameter int unsigned ROUNDS = 40,  // cipher cycles per block, 1..63
    parameter int unsigned RW     = 6    // rnd width, 2**RW > ROUNDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dec,
    state_update_ctrl_if.slave bus,
    output logic               enc,
    output logic               se,
    output logic [3:0]         decrypt,
    output logic               pdi_zero,
    output logic [RW-1:0]      rnd,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StTag,
        StDone
    } state_e;

    localparam logic [RW-1:0] RndLast = RW'(ROUNDS - 1);

    state_e        state_q;
    logic [1:0]    wcnt_q;
    logic [RW-1:0] rnd_q;
    logic          mode_q;
    logic          lastblk_q;

    // A LOAD word moves only when a new pdi word exists and its pdo word can leave in
    // the same cycle, since pdo is a combinational function of pdi.
    logic load_xfer;
    assign load_xfer = bus.bdi_valid & bus.bdo_ready;

    // Sequencer state, word counter, round counter and latched message attributes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            wcnt_q    <= 2'd0;
            rnd_q     <= '0;
            mode_q    <= 1'b0;
            lastblk_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q  <= dec;
                        wcnt_q  <= 2'd0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (load_xfer) begin
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == 2'd3) begin
                            // bdi_last only matters on the block's closing word.
                            lastblk_q <= bus.bdi_last;
                            rnd_q     <= '0;
                            state_q   <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (rnd_q == RndLast) begin
                        rnd_q   <= '0;
                        wcnt_q  <= 2'd0;
                        state_q <= lastblk_q ? StTag : StLoad;
                    end else begin
                        rnd_q <= rnd_q + RW'(1);
                    end
                end
                StTag: begin
                    if (bus.bdo_ready) begin
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == 2'd3) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    wcnt_q  <= 2'd0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output decode from registered state plus the bdi_valid/bdo_ready pass-through.
    always_comb begin
        bus.bdi_ready = 1'b0;
        bus.bdo_valid = 1'b0;
        bus.bdo_tag   = 1'b0;
        enc           = 1'b0;
        se            = 1'b1;
        decrypt       = 4'h0;
        pdi_zero      = 1'b0;
        rnd           = '0;
        busy          = (state_q != StIdle);
        done          = 1'b0;
        case (state_q)
            StLoad: begin
                bus.bdi_ready = bus.bdo_ready;
                bus.bdo_valid = bus.bdi_valid;
                enc           = load_xfer;
                decrypt       = mode_q ? bus.bdi_bval : 4'h0;
            end
            StRun: begin
                enc = 1'b1;
                se  = 1'b0;
                rnd = rnd_q;
            end
            StTag: begin
                bus.bdo_valid = 1'b1;
                bus.bdo_tag   = 1'b1;
                enc           = bus.bdo_ready;
                pdi_zero      = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_state_update_ctrl.sv
// Directed bench for state_update_ctrl: per-cycle vector tables for LOAD/TAG phases,
// loops for the RUN phase, and hand-written sequences for reset and back-to-back blocks.
module tb_state_update_ctrl;

    localparam int unsigned ROUNDS = 40;
    localparam int unsigned RW     = 6;

    // Expected flag vector layout: {bdi_ready, bdo_valid, bdo_tag, enc, se, pdi_zero, busy, done}
    localparam logic [7:0] FL_IDLE = 8'b00_0_0_1_0_0_0;
    localparam logic [7:0] FL_LXF  = 8'b11_0_1_1_0_1_0;  // LOAD word transfer
    localparam logic [7:0] FL_LST  = 8'b01_0_0_1_0_1_0;  // LOAD, valid but bdo_ready low
    localparam logic [7:0] FL_LNV  = 8'b10_0_0_1_0_1_0;  // LOAD, ready but no valid word
    localparam logic [7:0] FL_RUN  = 8'b00_0_1_0_0_1_0;
    localparam logic [7:0] FL_TXF  = 8'b01_1_1_1_1_1_0;  // TAG word transfer
    localparam logic [7:0] FL_TST  = 8'b01_1_0_1_1_1_0;  // TAG, bdo_ready low
    localparam logic [7:0] FL_DONE = 8'b00_0_0_1_0_1_1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dec;
    logic          enc;
    logic          se;
    logic [3:0]    decrypt;
    logic          pdi_zero;
    logic [RW-1:0] rnd;
    logic          busy;
    logic          done;

    state_update_ctrl_if bus ();

    state_update_ctrl #(
        .ROUNDS (ROUNDS),
        .RW     (RW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dec      (dec),
        .bus      (bus),
        .enc      (enc),
        .se       (se),
        .decrypt  (decrypt),
        .pdi_zero (pdi_zero),
        .rnd      (rnd),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start;
        logic       dec;
        logic       bv;
        logic       last;
        logic [3:0] bval;
        logic       br;
        logic [7:0] e_flags;
        logic [3:0] e_dec;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string nm, logic st, logic dc, logic bv, logic lst,
                                logic [3:0] bval, logic br, logic [7:0] ef, logic [3:0] ed);
        vec_t v;
        v.name    = nm;
        v.start   = st;
        v.dec     = dc;
        v.bv      = bv;
        v.last    = lst;
        v.bval    = bval;
        v.br      = br;
        v.e_flags = ef;
        v.e_dec   = ed;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(logic rs, logic st, logic dc, logic bv, logic lst, logic [3:0] bval,
                         logic br);
        @(negedge clk);
        rst           = rs;
        start         = st;
        dec           = dc;
        bus.bdi_valid = bv;
        bus.bdi_last  = lst;
        bus.bdi_bval  = bval;
        bus.bdo_ready = br;
        #1;
    endtask

    task automatic check(string nm, logic [7:0] ef, logic [3:0] ed, logic [RW-1:0] er);
        logic [7:0] af;
        af = {bus.bdi_ready, bus.bdo_valid, bus.bdo_tag, enc, se, pdi_zero, busy, done};
        n_chk++;
        if (af !== ef || decrypt !== ed || rnd !== er) begin
            n_fail++;
            $display("FAIL %s: got flags=%b decrypt=%h rnd=%0d, expected flags=%b decrypt=%h rnd=%0d",
                     nm, af, decrypt, rnd, ef, ed, er);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].start, tbl[i].dec, tbl[i].bv, tbl[i].last, tbl[i].bval, tbl[i].br);
            check(tbl[i].name, tbl[i].e_flags, tbl[i].e_dec, '0);
        end
        tbl.delete();
    endtask

    // RUN cycles with live-looking stream inputs, which must all be ignored.
    task automatic run_rounds(string nm, int n, logic st);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, st, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
            check(nm, FL_RUN, 4'h0, RW'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        check("reset0", FL_IDLE, 4'h0, '0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1);
        check("reset1", FL_IDLE, 4'h0, '0);

        // T1: reset while in RUN at rnd=17, start held during reset is ignored
        tbl.push_back(mk("t1_start", 1, 1, 0, 0, 4'h0, 0, FL_IDLE, 4'h0));
        tbl.push_back(mk("t1_ld0",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        tbl.push_back(mk("t1_ld1",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        tbl.push_back(mk("t1_ld2",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        tbl.push_back(mk("t1_ld3",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        run_tbl();
        run_rounds("t1_run", 17, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        check("t1_rnd17", FL_RUN, 4'h0, RW'(17));
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1);
        check("t1_rst_hold", FL_IDLE, 4'h0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        check("t1_after_rst", FL_IDLE, 4'h0, '0);

        // T2: single-block encrypt, no stalls
        tbl.push_back(mk("t2_start", 1, 0, 0, 0, 4'h0, 0, FL_IDLE, 4'h0));
        tbl.push_back(mk("t2_ld0",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t2_ld1",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t2_ld2",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t2_ld3",   0, 0, 1, 1, 4'hF, 1, FL_LXF,  4'h0));
        run_tbl();
        run_rounds("t2_run", ROUNDS, 1'b0);
        tbl.push_back(mk("t2_tag0",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t2_tag1",  0, 0, 1, 0, 4'hF, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t2_tag2",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t2_tag3",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t2_done",  0, 0, 0, 0, 4'h0, 1, FL_DONE, 4'h0));
        tbl.push_back(mk("t2_idle",  0, 0, 0, 0, 4'h0, 1, FL_IDLE, 4'h0));
        run_tbl();

        // T3: decrypt with a partial word and a LOAD bubble
        tbl.push_back(mk("t3_start", 1, 1, 0, 0, 4'h0, 0, FL_IDLE, 4'h0));
        tbl.push_back(mk("t3_ld0",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        tbl.push_back(mk("t3_bubble",0, 0, 0, 0, 4'hF, 1, FL_LNV,  4'hF));
        tbl.push_back(mk("t3_ld1",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        tbl.push_back(mk("t3_ld2",   0, 0, 1, 0, 4'h3, 1, FL_LXF,  4'h3));
        tbl.push_back(mk("t3_ld3",   0, 0, 1, 1, 4'hF, 1, FL_LXF,  4'hF));
        run_tbl();
        run_rounds("t3_run", ROUNDS, 1'b0);
        tbl.push_back(mk("t3_tag0",  0, 0, 0, 0, 4'hF, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t3_tag1",  0, 0, 0, 0, 4'hF, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t3_tag2",  0, 0, 0, 0, 4'hF, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t3_tag3",  0, 0, 0, 0, 4'hF, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t3_done",  0, 0, 0, 0, 4'h0, 0, FL_DONE, 4'h0));
        tbl.push_back(mk("t3_idle",  0, 0, 0, 0, 4'h0, 0, FL_IDLE, 4'h0));
        run_tbl();

        // T4: backpressure in LOAD (word 1) and TAG (word 2)
        tbl.push_back(mk("t4_start", 1, 0, 0, 0, 4'h0, 0, FL_IDLE, 4'h0));
        tbl.push_back(mk("t4_ld0",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t4_lst0",  0, 0, 1, 0, 4'hF, 0, FL_LST,  4'h0));
        tbl.push_back(mk("t4_lst1",  0, 0, 1, 0, 4'hF, 0, FL_LST,  4'h0));
        tbl.push_back(mk("t4_lst2",  0, 0, 1, 0, 4'hF, 0, FL_LST,  4'h0));
        tbl.push_back(mk("t4_ld1",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t4_ld2",   0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t4_ld3",   0, 0, 1, 1, 4'hF, 1, FL_LXF,  4'h0));
        run_tbl();
        run_rounds("t4_run", ROUNDS, 1'b0);
        tbl.push_back(mk("t4_tag0",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t4_tag1",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t4_tst0",  0, 0, 0, 0, 4'h0, 0, FL_TST,  4'h0));
        tbl.push_back(mk("t4_tst1",  0, 0, 1, 0, 4'h0, 0, FL_TST,  4'h0));
        tbl.push_back(mk("t4_tst2",  0, 0, 0, 0, 4'h0, 0, FL_TST,  4'h0));
        tbl.push_back(mk("t4_tag2",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t4_tag3",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t4_done",  0, 0, 0, 0, 4'h0, 1, FL_DONE, 4'h0));
        tbl.push_back(mk("t4_idle",  0, 0, 0, 0, 4'h0, 1, FL_IDLE, 4'h0));
        run_tbl();

        // T5: two blocks back to back; bdi_last on block-1 word 1 must be ignored
        tbl.push_back(mk("t5_start", 1, 1, 0, 0, 4'h0, 0, FL_IDLE, 4'h0));
        tbl.push_back(mk("t5_b1w0",  0, 0, 1, 0, 4'h1, 1, FL_LXF,  4'h1));
        tbl.push_back(mk("t5_b1w1",  0, 0, 1, 1, 4'h2, 1, FL_LXF,  4'h2));
        tbl.push_back(mk("t5_b1w2",  0, 0, 1, 0, 4'h4, 1, FL_LXF,  4'h4));
        tbl.push_back(mk("t5_b1w3",  0, 0, 1, 0, 4'h8, 1, FL_LXF,  4'h8));
        run_tbl();
        run_rounds("t5_run1", ROUNDS, 1'b0);
        tbl.push_back(mk("t5_b2w0",  0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        tbl.push_back(mk("t5_b2w1",  0, 0, 1, 0, 4'hF, 1, FL_LXF,  4'hF));
        tbl.push_back(mk("t5_b2w2",  0, 0, 1, 0, 4'h7, 1, FL_LXF,  4'h7));
        tbl.push_back(mk("t5_b2w3",  0, 0, 1, 1, 4'hF, 1, FL_LXF,  4'hF));
        run_tbl();
        run_rounds("t5_run2", ROUNDS, 1'b0);
        tbl.push_back(mk("t5_tag0",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t5_tag1",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t5_tag2",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t5_tag3",  0, 0, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t5_done",  0, 0, 0, 0, 4'h0, 1, FL_DONE, 4'h0));
        tbl.push_back(mk("t5_idle",  0, 0, 0, 0, 4'h0, 1, FL_IDLE, 4'h0));
        run_tbl();

        // T6: start/dec pulsed outside IDLE leave mode and sequencing untouched
        tbl.push_back(mk("t6_start", 1, 0, 0, 0, 4'h0, 0, FL_IDLE, 4'h0));
        tbl.push_back(mk("t6_ld0",   1, 1, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t6_ld1",   1, 1, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t6_ld2",   1, 1, 1, 0, 4'hF, 1, FL_LXF,  4'h0));
        tbl.push_back(mk("t6_ld3",   1, 1, 1, 1, 4'hF, 1, FL_LXF,  4'h0));
        run_tbl();
        run_rounds("t6_run", ROUNDS, 1'b1);
        tbl.push_back(mk("t6_tag0",  1, 1, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t6_tag1",  1, 1, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t6_tag2",  1, 1, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t6_tag3",  1, 1, 0, 0, 4'h0, 1, FL_TXF,  4'h0));
        tbl.push_back(mk("t6_done",  1, 1, 0, 0, 4'h0, 1, FL_DONE, 4'h0));
        tbl.push_back(mk("t6_idle0", 0, 0, 0, 0, 4'h0, 1, FL_IDLE, 4'h0));
        tbl.push_back(mk("t6_idle1", 0, 0, 1, 0, 4'hF, 1, FL_IDLE, 4'h0));
        run_tbl();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
